// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types and helpers for the pooling input feeder
package pool_pkg;

   // 3-bit state codes for the streamer FSM
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_GAP   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE  = S_IDLE,
      ST_READ  = S_READ,
      ST_GAP   = S_GAP,
      ST_DRAIN = S_DRAIN,
      ST_FIN   = S_FIN
   } stream_state_t;

   function automatic int clog2_f(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // counter width able to hold 0..n-1, never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : clog2_f(n);
   endfunction

   function automatic int frame_size(input int ci, input int ifm_size);
      return ci * ifm_size * ifm_size;
   endfunction

endpackage

// File: rtl/pool_ifm_streamer_if.sv
// rtl/pool_ifm_streamer_if.sv - control, SRAM and pixel-stream bundle of the feeder
interface pool_ifm_streamer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
);
   logic                  start;
   logic                  stall;
   logic                  mem_rd_en;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] pix_out;
   logic                  in_valid;
   logic                  row_last;
   logic                  ch_last;
   logic                  busy;
   logic                  done;

   modport master (
      input  start, stall, mem_rdata,
      output mem_rd_en, mem_addr, pix_out, in_valid, row_last, ch_last, busy, done
   );

   modport slave (
      output start, stall, mem_rdata,
      input  mem_rd_en, mem_addr, pix_out, in_valid, row_last, ch_last, busy, done
   );
endinterface

// File: rtl/pool_skid_reg.sv
// rtl/pool_skid_reg.sv - one-entry holding register for read data returning under stall
module pool_skid_reg #(
   parameter int WIDTH = 10
) (
   input  logic             clk1,
   input  logic             rst_n,
   input  logic             load,
   input  logic             unload,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             full
);

   // capture on load, release on unload; the two never coincide in the feeder
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         q    <= '0;
         full <= 1'b0;
      end else if (load) begin
         q    <= d;
         full <= 1'b1;
      end else if (unload) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/pool_ifm_streamer.sv
// rtl/pool_ifm_streamer.sv - raster SRAM reader feeding pixels to the pool stage
module pool_ifm_streamer
   import pool_pkg::*;
#(
   parameter int IFM_SIZE   = 9,
   parameter int CI         = 3,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10,
   parameter int ROW_GAP    = 1
) (
   input  logic clk1,
   input  logic rst_n,
   pool_ifm_streamer_if.master bus
);

   localparam int CW = cnt_width(IFM_SIZE);
   localparam int HW = cnt_width(CI);
   localparam int GW = cnt_width(ROW_GAP);
   localparam int SW = DATA_WIDTH + 2;
   localparam int FRAME_PIX = frame_size(CI, IFM_SIZE);

   localparam logic [CW-1:0] POS_LAST = CW'(IFM_SIZE - 1);
   localparam logic [HW-1:0] CH_LAST  = HW'(CI - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(ROW_GAP - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(FRAME_PIX - 1);

   stream_state_t         state;
   logic [CW-1:0]         col;
   logic [CW-1:0]         row;
   logic [HW-1:0]         ch;
   logic [GW-1:0]         gap_cnt;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [ADDR_WIDTH-1:0] last_addr;
   logic                  busy_r;
   logic                  done_r;

   logic                  rd_pending;
   logic                  tag_rl;
   logic                  tag_cl;
   logic [DATA_WIDTH-1:0] out_pix;
   logic                  out_valid;
   logic                  out_rl;
   logic                  out_cl;

   logic                  skid_full;
   logic [SW-1:0]         skid_q;
   logic                  skid_load;
   logic                  skid_unload;

   logic                  rd_fire;
   logic                  col_end;
   logic                  row_end;
   logic                  drained;

   // a read goes out only when nothing downstream is backed up
   assign rd_fire     = (state == ST_READ) && !bus.stall && !skid_full;
   assign col_end     = (col == POS_LAST);
   assign row_end     = (row == POS_LAST);
   assign skid_load   = bus.stall && rd_pending;
   assign skid_unload = !bus.stall && skid_full;
   assign drained     = !rd_pending && !skid_full && (!out_valid || !bus.stall);

   assign bus.mem_rd_en = rd_fire;
   assign bus.mem_addr  = rd_fire ? addr_cnt : last_addr;
   assign bus.pix_out   = out_pix;
   assign bus.in_valid  = out_valid;
   assign bus.row_last  = out_rl;
   assign bus.ch_last   = out_cl;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;

   // frame sequencing, raster counters and the incremental read address
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         col       <= '0;
         row       <= '0;
         ch        <= '0;
         gap_cnt   <= '0;
         addr_cnt  <= '0;
         last_addr <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state    <= ST_READ;
                  col      <= '0;
                  row      <= '0;
                  ch       <= '0;
                  gap_cnt  <= '0;
                  addr_cnt <= '0;
                  busy_r   <= 1'b1;
               end
            end
            ST_READ: begin
               if (rd_fire) begin
                  last_addr <= addr_cnt;
                  addr_cnt  <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + ADDR_WIDTH'(1);
                  if (col_end) begin
                     col     <= '0;
                     gap_cnt <= '0;
                     if (row_end && (ch == CH_LAST)) begin
                        state <= ST_DRAIN;
                     end else begin
                        state <= ST_GAP;
                     end
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            ST_GAP: begin
               if (!bus.stall) begin
                  if (gap_cnt == GAP_LAST) begin
                     gap_cnt <= '0;
                     state   <= ST_READ;
                     if (row_end) begin
                        row <= '0;
                        ch  <= ch + HW'(1);
                     end else begin
                        row <= row + CW'(1);
                     end
                  end else begin
                     gap_cnt <= gap_cnt + GW'(1);
                  end
               end
            end
            ST_DRAIN: begin
               if (drained) begin
                  state  <= ST_FIN;
                  done_r <= 1'b1;
               end
            end
            ST_FIN: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
            end
            default: begin
               state  <= ST_IDLE;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

   // read-side pipeline stage: row/channel tags follow the SRAM latency
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         rd_pending <= 1'b0;
         tag_rl     <= 1'b0;
         tag_cl     <= 1'b0;
      end else begin
         rd_pending <= rd_fire;
         tag_rl     <= rd_fire && col_end;
         tag_cl     <= rd_fire && col_end && row_end;
      end
   end

   // output register: holds under stall, refills from the skid before fresh data
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         out_pix   <= '0;
         out_valid <= 1'b0;
         out_rl    <= 1'b0;
         out_cl    <= 1'b0;
      end else if (!bus.stall) begin
         if (skid_full) begin
            {out_pix, out_rl, out_cl} <= skid_q;
            out_valid <= 1'b1;
         end else if (rd_pending) begin
            out_pix   <= bus.mem_rdata;
            out_rl    <= tag_rl;
            out_cl    <= tag_cl;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
            out_rl    <= 1'b0;
            out_cl    <= 1'b0;
         end
      end
   end

   pool_skid_reg #(
      .WIDTH (SW)
   ) u_skid (
      .clk1   (clk1),
      .rst_n  (rst_n),
      .load   (skid_load),
      .unload (skid_unload),
      .d      ({bus.mem_rdata, tag_rl, tag_cl}),
      .q      (skid_q),
      .full   (skid_full)
   );

endmodule

// File: tb/tb_pool_ifm_streamer.sv
// tb/tb_pool_ifm_streamer.sv - directed self-checking bench for the pooling feeder
module tb_pool_ifm_streamer;

   logic clk1 = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_mis = 0;

   always #5 clk1 = ~clk1;
   always @(posedge clk1) cyc <= cyc + 1;

   pool_ifm_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus_a ();
   pool_ifm_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) bus_b ();

   pool_ifm_streamer #(
      .IFM_SIZE(9), .CI(3), .DATA_WIDTH(8), .ADDR_WIDTH(10), .ROW_GAP(1)
   ) dut_a (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus_a.master)
   );

   pool_ifm_streamer #(
      .IFM_SIZE(4), .CI(1), .DATA_WIDTH(8), .ADDR_WIDTH(10), .ROW_GAP(3)
   ) dut_b (
      .clk1  (clk1),
      .rst_n (rst_n),
      .bus   (bus_b.master)
   );

   // SRAM images: each word holds its own address mod 256
   always @(posedge clk1) begin
      if (bus_a.mem_rd_en) bus_a.mem_rdata <= bus_a.mem_addr[7:0];
      if (bus_b.mem_rd_en) bus_b.mem_rdata <= bus_b.mem_addr[7:0];
   end

   int px_a[$];
   bit rl_a[$];
   bit cl_a[$];
   int cy_a[$];
   int done_cnt_a;
   int done_cyc_a;
   int first_rd_cyc_a;
   int first_rd_addr_a;
   int first_v_cyc_a;
   int rd_cnt_a[0:1023];

   int px_b[$];
   bit rl_b[$];
   bit cl_b[$];
   int cy_b[$];
   int done_cnt_b;

   // log accepted pixels late in each cycle, well clear of the active edge
   always @(negedge clk1) begin
      #3;
      if (bus_a.in_valid && !bus_a.stall) begin
         px_a.push_back(int'(bus_a.pix_out));
         rl_a.push_back(bus_a.row_last);
         cl_a.push_back(bus_a.ch_last);
         cy_a.push_back(cyc);
      end
      if (bus_a.in_valid && first_v_cyc_a < 0) first_v_cyc_a = cyc;
      if (bus_a.done) begin
         done_cnt_a = done_cnt_a + 1;
         done_cyc_a = cyc;
      end
      if (bus_a.mem_rd_en) begin
         if (first_rd_cyc_a < 0) begin
            first_rd_cyc_a  = cyc;
            first_rd_addr_a = int'(bus_a.mem_addr);
         end
         rd_cnt_a[bus_a.mem_addr] = rd_cnt_a[bus_a.mem_addr] + 1;
      end
      if (bus_b.in_valid && !bus_b.stall) begin
         px_b.push_back(int'(bus_b.pix_out));
         rl_b.push_back(bus_b.row_last);
         cl_b.push_back(bus_b.ch_last);
         cy_b.push_back(cyc);
      end
      if (bus_b.done) done_cnt_b = done_cnt_b + 1;
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_mis = n_mis + 1;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_a();
      px_a.delete();
      rl_a.delete();
      cl_a.delete();
      cy_a.delete();
      done_cnt_a      = 0;
      done_cyc_a      = -1;
      first_rd_cyc_a  = -1;
      first_rd_addr_a = -1;
      first_v_cyc_a   = -1;
      for (int i = 0; i < 1024; i++) rd_cnt_a[i] = 0;
   endtask

   task automatic pulse_start_a();
      @(negedge clk1);
      bus_a.start = 1'b1;
      @(negedge clk1);
      bus_a.start = 1'b0;
   endtask

   task automatic wait_done_a(input string tag);
      for (int i = 0; i < 2000 && done_cnt_a == 0; i++) @(negedge clk1);
      check_eq({tag, "_done_seen"}, int'(done_cnt_a > 0), 1);
      repeat (6) @(negedge clk1);
   endtask

   // returns at the negedge of the cycle in which 'value' is presented
   task automatic wait_pix_a(input string tag, input int value);
      bit found;
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         @(negedge clk1);
         if (bus_a.in_valid && int'(bus_a.pix_out) == value) found = 1'b1;
      end
      check_eq({tag, "_pix_found"}, int'(found), 1);
   endtask

   task automatic check_frame_a(input string tag);
      int bad_val;
      int bad_rd;
      bad_val = 0;
      bad_rd  = 0;
      check_eq({tag, "_count"}, px_a.size(), 243);
      foreach (px_a[i]) if (px_a[i] != i) bad_val++;
      check_eq({tag, "_order_bad"}, bad_val, 0);
      for (int a = 0; a < 243; a++) if (rd_cnt_a[a] != 1) bad_rd++;
      for (int a = 243; a < 1024; a++) if (rd_cnt_a[a] != 0) bad_rd++;
      check_eq({tag, "_reads_bad"}, bad_rd, 0);
      check_eq({tag, "_done_cnt"}, done_cnt_a, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad_rl;
      int bad_cl;
      int bad_gap;
      int exp_gap;

      rst_n = 1'b0;
      bus_a.start = 1'b0;
      bus_a.stall = 1'b0;
      bus_b.start = 1'b0;
      bus_b.stall = 1'b0;
      clear_a();
      done_cnt_b = 0;
      repeat (3) @(negedge clk1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk1);

      // reset state
      check_eq("rst_busy",     int'(bus_a.busy), 0);
      check_eq("rst_in_valid", int'(bus_a.in_valid), 0);
      check_eq("rst_rd_en",    int'(bus_a.mem_rd_en), 0);
      check_eq("rst_done",     int'(bus_a.done), 0);
      check_eq("rst_pix",      int'(bus_a.pix_out), 0);
      check_eq("rst_addr",     int'(bus_a.mem_addr), 0);

      // stall in idle does nothing
      bus_a.stall = 1'b1;
      repeat (3) @(negedge clk1);
      check_eq("idle_stall_busy", int'(bus_a.busy), 0);
      bus_a.stall = 1'b0;

      // t1: free-running frame
      clear_a();
      pulse_start_a();
      #1;
      check_eq("t1_busy", int'(bus_a.busy), 1);
      wait_done_a("t1");
      check_frame_a("t1");
      bad_rl  = 0;
      bad_cl  = 0;
      bad_gap = 0;
      foreach (px_a[i]) begin
         if (rl_a[i] != ((i % 9) == 8)) bad_rl++;
         if (cl_a[i] != ((i % 81) == 80)) bad_cl++;
         if (i > 0) begin
            exp_gap = (((i - 1) % 9) == 8) ? 2 : 1;
            if (cy_a[i] - cy_a[i-1] != exp_gap) bad_gap++;
         end
      end
      check_eq("t1_row_last_bad", bad_rl, 0);
      check_eq("t1_ch_last_bad", bad_cl, 0);
      check_eq("t1_gap_bad", bad_gap, 0);
      if (px_a.size() == 243) check_eq("t1_done_latency", done_cyc_a - cy_a[242], 1);
      check_eq("t1_first_latency", first_v_cyc_a - first_rd_cyc_a, 2);
      check_eq("t1_first_addr", first_rd_addr_a, 0);
      check_eq("t1_busy_after", int'(bus_a.busy), 0);

      // t2: 3-cycle stall starting when pixel 4 is presented
      clear_a();
      pulse_start_a();
      wait_pix_a("t2", 4);
      bus_a.stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #3;
         check_eq("t2_hold_pix", int'(bus_a.pix_out), 4);
         check_eq("t2_hold_valid", int'(bus_a.in_valid), 1);
         check_eq("t2_no_rd", int'(bus_a.mem_rd_en), 0);
         @(negedge clk1);
      end
      bus_a.stall = 1'b0;
      wait_done_a("t2");
      check_frame_a("t2");

      // t3: stall the cycle read data for address 40 returns
      clear_a();
      pulse_start_a();
      begin
         bit found;
         found = 1'b0;
         for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk1);
            if (bus_a.mem_rd_en && int'(bus_a.mem_addr) == 40) found = 1'b1;
         end
         check_eq("t3_rd40_found", int'(found), 1);
      end
      @(negedge clk1);
      bus_a.stall = 1'b1;
      @(negedge clk1);
      bus_a.stall = 1'b0;
      #3;
      check_eq("t3_skid_full", int'(dut_a.u_skid.full), 1);
      check_eq("t3_skid_data", int'(dut_a.u_skid.q[9:2]), 40);
      check_eq("t3_out_pix", int'(bus_a.pix_out), 39);
      wait_done_a("t3");
      check_frame_a("t3");

      // t4: start while busy is ignored
      clear_a();
      pulse_start_a();
      wait_pix_a("t4", 100);
      bus_a.start = 1'b1;
      @(negedge clk1);
      bus_a.start = 1'b0;
      wait_done_a("t4");
      check_frame_a("t4");
      repeat (20) @(negedge clk1);
      check_eq("t4_no_restart", px_a.size(), 243);
      check_eq("t4_busy_idle", int'(bus_a.busy), 0);

      // t5: asynchronous reset mid-frame, then a fresh frame
      clear_a();
      pulse_start_a();
      wait_pix_a("t5", 150);
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_valid", int'(bus_a.in_valid), 0);
      check_eq("t5_rst_busy",  int'(bus_a.busy), 0);
      check_eq("t5_rst_rd_en", int'(bus_a.mem_rd_en), 0);
      check_eq("t5_rst_pix",   int'(bus_a.pix_out), 0);
      check_eq("t5_rst_rl",    int'(bus_a.row_last), 0);
      check_eq("t5_rst_cl",    int'(bus_a.ch_last), 0);
      check_eq("t5_rst_addr",  int'(bus_a.mem_addr), 0);
      repeat (2) @(negedge clk1);
      rst_n = 1'b1;
      @(negedge clk1);
      clear_a();
      pulse_start_a();
      wait_done_a("t5");
      check_eq("t5_first_addr", first_rd_addr_a, 0);
      check_eq("t5_first_pix", (px_a.size() > 0) ? px_a[0] : -1, 0);
      check_frame_a("t5");

      // t6: 4x4 single channel with 3-cycle row gap
      px_b.delete();
      rl_b.delete();
      cl_b.delete();
      cy_b.delete();
      done_cnt_b = 0;
      @(negedge clk1);
      bus_b.start = 1'b1;
      @(negedge clk1);
      bus_b.start = 1'b0;
      for (int i = 0; i < 500 && done_cnt_b == 0; i++) @(negedge clk1);
      check_eq("t6_done_seen", int'(done_cnt_b > 0), 1);
      repeat (6) @(negedge clk1);
      check_eq("t6_count", px_b.size(), 16);
      bad_rl  = 0;
      bad_cl  = 0;
      bad_gap = 0;
      foreach (px_b[i]) begin
         if (px_b[i] != i) bad_gap++;
         if (rl_b[i] != ((i % 4) == 3)) bad_rl++;
         if (cl_b[i] != (i == 15)) bad_cl++;
         if (i > 0) begin
            exp_gap = (((i - 1) % 4) == 3) ? 4 : 1;
            if (cy_b[i] - cy_b[i-1] != exp_gap) bad_gap++;
         end
      end
      check_eq("t6_order_gap_bad", bad_gap, 0);
      check_eq("t6_row_last_bad", bad_rl, 0);
      check_eq("t6_ch_last_bad", bad_cl, 0);
      check_eq("t6_done_cnt", done_cnt_b, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/pool_ifm_streamer.md
Name: pool_ifm_streamer

Overview:
- Upstream feeder for the pooling stage.
- Reads a CI x IFM_SIZE x IFM_SIZE feature map from a single-port synchronous SRAM (1-cycle read latency) in channel-major, row-major raster order.
- Emits one pixel per cycle with in_valid. ROW_GAP idle cycles follow every row, giving the pool controller its row and channel turnaround cycles.
- Supports a downstream stall with a one-entry skid buffer, so no pixel is lost or duplicated.

Parameters:
IFM_SIZE, 9, feature-map width and height in pixels
CI, 3, channel count
DATA_WIDTH, 8, pixel width
ADDR_WIDTH, 10, SRAM address width; must satisfy CI*IFM_SIZE*IFM_SIZE <= 2**ADDR_WIDTH
ROW_GAP, 1, idle cycles inserted after each row (>=1)

Ports:
clk1  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins a frame when idle
stall  in  1  downstream cannot accept a pixel this cycle
mem_rd_en  out  1  SRAM read strobe
mem_addr  out  ADDR_WIDTH  SRAM read address
mem_rdata  in  DATA_WIDTH  SRAM data, valid the cycle after mem_rd_en
pix_out  out  DATA_WIDTH  pixel to pool stage
in_valid  out  1  pix_out valid
row_last  out  1  qualifies the last pixel of a row
ch_last  out  1  qualifies the last pixel of a channel
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the final pixel is accepted

Behaviour:
- Reset (async, any time, including mid-frame) forces IDLE and zeroes all counters, the skid register, and every output. Pending reads are discarded.
- FSM states: IDLE, READ, GAP, DRAIN, FIN.
- IDLE:
  - start=1 -> READ; col, row and ch are zeroed.
  - busy=0.
  - start is ignored in every other state.
- READ:
  - Each cycle with stall=0 and the skid empty: mem_rd_en=1, mem_addr=ch*IFM_SIZE*IFM_SIZE + row*IFM_SIZE + col, then col advances.
  - The address is kept by an incremental counter, not a multiplier.
  - When col==IFM_SIZE-1 is issued, col wraps to 0 and the state moves to GAP, or to DRAIN if row==IFM_SIZE-1 and ch==CI-1.
- GAP:
  - mem_rd_en=0 for exactly ROW_GAP cycles. Stall cycles do not count.
  - Then row++ (wrap to 0 with ch++ at IFM_SIZE-1) and return to READ.
- DRAIN: no reads; wait until the output register and skid are empty and the last pixel has been accepted -> FIN.
- FIN: done=1 for one cycle -> IDLE. busy=1 in every state except IDLE.
- Datapath latency: the read issued at cycle t gives in_valid=1 at t+2 (pix_out registered from mem_rdata). row_last and ch_last travel in the same pipeline as the read.
- Stall rules:
  - stall=1: pix_out, in_valid, row_last and ch_last hold; no new read is issued.
  - Read data returning during stall is captured in the skid.
  - On stall release the skid drains first; reads resume the cycle after the skid empties.
  - A pixel is accepted when in_valid=1 and stall=0.
- stall in IDLE has no effect.
- in_valid is 0 in every GAP-caused bubble.
- Exact pixel count per frame is CI*IFM_SIZE*IFM_SIZE, each address read exactly once.
- mem_addr holds its last value when mem_rd_en=0.

Decomposition:
- Shared package pool_pkg:
  - FSM state encoding for pool_ifm_streamer (3-bit localparams).
  - A function computing the frame size CI*IFM_SIZE*IFM_SIZE.
  - clog2 helper for counter widths.
- One natural sub-module, pool_skid_reg: the one-entry DATA_WIDTH+2 bit holding register with valid, load/unload and full flag.
- Address generation and the FSM remain in the top.

Test Plan:
- Default parameters, start, stall=0, SRAM preloaded addr==data mod 256:
  - exactly 243 accepted pixels with values 0..242 in order;
  - in_valid low for one cycle after every 9th pixel;
  - row_last on pixels 8, 17, ...; ch_last on 80, 161, 242;
  - done 1 cycle after pixel 242; first in_valid 2 cycles after the first mem_rd_en.
- Stall high for 3 cycles starting the cycle pixel 4 is presented:
  - pix_out holds 4 for 3 cycles; no mem_rd_en during the stall;
  - sequence continues 5, 6, ... with no loss or duplicates.
- Stall asserted the cycle a read is in flight:
  - the skid captures the returned data;
  - on release, output order is unchanged and the total remains 243.
- start pulsed while busy at pixel 100: ignored; the frame completes normally with one done.
- rst_n low at pixel 150 for 2 cycles:
  - all outputs 0 immediately, busy=0;
  - a new start produces a full fresh frame beginning at address 0.
- ROW_GAP=3, IFM_SIZE=4, CI=1: exactly 3 idle cycles between rows, 16 pixels, done once.
